// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware FIFO for one router output channel with fill level, packet-end strobe and sticky errors
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int LEN_MSB  = 7,
  parameter int LEN_LSB  = 2,
  parameter int AF_LEVEL = 14
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_soft_rst,
  input  logic                     i_wr_en,
  input  logic                     i_lfd_state,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_dout,
  output logic                     o_dout_valid,
  output logic                     o_dout_hdr,
  output logic                     o_pkt_end,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic [$clog2(DEPTH):0]   o_fill_count,
  output logic                     o_ovf_err,
  output logic                     o_udf_err,
  output logic                     o_frm_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LEN_MSB - LEN_LSB + 2;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr, r_fill;
  logic [CW-1:0]     r_len;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid, r_hdr, r_end, r_ovf, r_udf, r_frm;
  logic [DATA_W:0]   w_word;
  logic              w_flush, w_wr, w_rd;
  assign o_empty       = r_wr_ptr == r_rd_ptr;
  assign o_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_almost_full = r_fill >= (AW+1)'(AF_LEVEL);
  assign o_fill_count  = r_fill;
  assign o_dout        = r_dout;
  assign o_dout_valid  = r_valid;
  assign o_dout_hdr    = r_hdr;
  assign o_pkt_end     = r_end;
  assign o_ovf_err     = r_ovf;
  assign o_udf_err     = r_udf;
  assign o_frm_err     = r_frm;
  assign w_flush       = i_rst || i_soft_rst;
  assign w_wr          = i_wr_en && !o_full && !w_flush;
  assign w_rd          = i_rd_en && !o_empty && !w_flush;
  assign w_word        = r_mem[r_rd_ptr[AW-1:0]];
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {i_lfd_state, i_din};
  end
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_len    <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_hdr    <= 1'b0;
      r_end    <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_frm    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (AW+1)'(w_wr);
      r_rd_ptr <= r_rd_ptr + (AW+1)'(w_rd);
      r_fill   <= r_fill + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      r_valid  <= w_rd;
      r_end    <= w_rd && !w_word[DATA_W] && r_len == CW'(1);
      if (i_wr_en && o_full) r_ovf <= 1'b1;
      if (i_rd_en && o_empty) r_udf <= 1'b1;
      if (w_rd) begin
        {r_hdr, r_dout} <= w_word;
        // a header reloads payload length plus one for the trailing parity byte
        if (w_word[DATA_W]) begin
          r_len <= CW'(w_word[LEN_MSB:LEN_LSB]) + CW'(1);
          if (r_len != '0) r_frm <= 1'b1;
        end else if (r_len != '0) begin
          r_len <= r_len - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: randomized and directed checks of router_pkt_fifo against a queue-based packet model
module tb_router_pkt_fifo;
  localparam int DEPTH = 16;
  logic       clk = 1'b0, rst = 1'b1, soft_rst = 1'b0, wr_en = 1'b0, lfd = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid, dout_hdr, pkt_end, empty, full, almost_full, ovf_err, udf_err, frm_err;
  logic [4:0] fill_count;
  int         n_chk = 0, n_err = 0;
  bit         cmp_en = 1'b0;
  logic [8:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_valid = 1'b0, m_hdr = 1'b0, m_end = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, m_frm = 1'b0;
  int         m_len = 0;

  router_pkt_fifo dut (
    .i_clk(clk), .i_rst(rst), .i_soft_rst(soft_rst), .i_wr_en(wr_en), .i_lfd_state(lfd),
    .i_din(din), .i_rd_en(rd_en), .o_dout(dout), .o_dout_valid(dout_valid), .o_dout_hdr(dout_hdr),
    .o_pkt_end(pkt_end), .o_empty(empty), .o_full(full), .o_almost_full(almost_full),
    .o_fill_count(fill_count), .o_ovf_err(ovf_err), .o_udf_err(udf_err), .o_frm_err(frm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [8:0] w;
    bit is_full, is_empty;
    if (rst || soft_rst) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_hdr = 0; m_end = 0; m_len = 0;
      m_ovf = 0; m_udf = 0; m_frm = 0;
    end else begin
      is_full  = q.size() == DEPTH;
      is_empty = q.size() == 0;
      if (wr_en && is_full) m_ovf = 1;
      if (rd_en && is_empty) m_udf = 1;
      m_valid = rd_en && !is_empty;
      m_end = 0;
      if (m_valid) begin
        w = q.pop_front();
        {m_hdr, m_dout} = w;
        if (w[8]) begin
          if (m_len != 0) m_frm = 1;
          m_len = int'(w[7:2]) + 1;
        end else if (m_len != 0) begin
          m_end = m_len == 1;
          m_len--;
        end
      end
      if (wr_en && !is_full) q.push_back({lfd, din});
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
    chk("dout_hdr", dout_hdr, m_hdr);
    chk("pkt_end", pkt_end, m_end);
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("almost_full", almost_full, q.size() >= 14);
    chk("fill_count", fill_count, q.size());
    chk("ovf_err", ovf_err, m_ovf);
    chk("udf_err", udf_err, m_udf);
    chk("frm_err", frm_err, m_frm);
  end

  task automatic cyc(input logic wr, input logic l, input logic [7:0] d, input logic rd, input logic sr = 1'b0);
    wr_en = wr; lfd = l; din = d; rd_en = rd; soft_rst = sr;
    @(posedge clk);
    #2;
    wr_en = 0; rd_en = 0; soft_rst = 0; lfd = 0;
  endtask

  initial begin
    logic [7:0] exp_t2 [5];
    exp_t2 = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'hAA};
    rst = 1; wr_en = 1; din = 8'h55;
    @(posedge clk); #2;
    cmp_en = 1;
    @(posedge clk); #2;
    chk("rst_empty", empty, 1); chk("rst_fill", fill_count, 0); chk("rst_dout", dout, 0);
    rst = 0; wr_en = 0;
    cyc(1, 1, 8'h0C, 0);
    cyc(1, 0, 8'h11, 0); cyc(1, 0, 8'h22, 0); cyc(1, 0, 8'h33, 0); cyc(1, 0, 8'hAA, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      chk("t2_dout", dout, exp_t2[i]);
      chk("t2_hdr", dout_hdr, i == 0);
      chk("t2_end", pkt_end, i == 4);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'(i), 0);
      chk("t3_af", almost_full, i >= 13);
    end
    chk("t3_full", full, 1); chk("t3_fill", fill_count, 16);
    cyc(1, 0, 8'hEE, 0);
    chk("t3_ovf", ovf_err, 1); chk("t3_fill17", fill_count, 16);
    cyc(1, 0, 8'hEE, 1);
    chk("t3_rdwr_fill", fill_count, 15); chk("t3_rdwr_dout", dout, 8'h00);
    cyc(0, 0, 0, 0, 1);
    chk("t4_flush_ovf", ovf_err, 0);
    cyc(0, 0, 0, 1);
    chk("t4_udf", udf_err, 1); chk("t4_dout", dout, 0); chk("t4_valid", dout_valid, 0);
    cyc(1, 0, 8'h77, 1);
    chk("t4_fill", fill_count, 1); chk("t4_novalid", dout_valid, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 8'h08, 0); cyc(1, 0, 8'h41, 0); cyc(1, 1, 8'h0C, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h50 + i), 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("t5_frm", frm_err, 1); chk("t5_hdr", dout, 8'h0C);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      chk("t5_end", pkt_end, i == 3);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 8'h10, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(i + 1), 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_empty", empty, 1); chk("t6_dout", dout, 0); chk("t6_frm", frm_err, 0); chk("t6_udf", udf_err, 0);
    for (int p = 0; p < 3; p++) begin
      cyc(1, 1, 8'h38, 0);
      for (int i = 0; i < 15; i++) cyc(1, 0, 8'(p * 16 + i), 0);
      chk("t6_full", full, 1);
      for (int i = 0; i < 16; i++) begin
        cyc(0, 0, 0, 1);
        chk("t6_end", pkt_end, i == 15);
        if (i > 0) chk("t6_data", dout, 8'(p * 16 + i - 1));
      end
    end
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 7) == 0, 8'($urandom),
          $urandom_range(0, 99) < 50, $urandom_range(0, 127) == 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
